// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch stage, the instruction SRAM read port and ID.
interface inst_fetch_if;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [33:0] if_to_id_bus;
    logic [31:0] inst_to_id;

    // Fetch stage side.
    modport master (
        input  stall,
        input  br_bus,
        input  inst_sram_rdata,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        output if_to_id_bus,
        output inst_to_id
    );

    // Environment side: pipeline control, ID and the SRAM model.
    modport slave (
        output stall,
        output br_bus,
        output inst_sram_rdata,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  if_to_id_bus,
        input  inst_to_id
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM read port,
// buffers redirects that arrive while the PC is held, and keeps a one-entry
// skid buffer so ID sees a stable instruction word while it is stalled.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PC_STEP  = 4;

    // Decoded inputs
    logic            br_e;
    logic [XLEN-1:0] br_addr;
    logic            pc_stop;
    logic            ifid_stop;

    // Stage state
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ce_q, ce_d;
    logic            redir_pend_q, redir_pend_d;
    logic [XLEN-1:0] redir_addr_q, redir_addr_d;
    logic [XLEN-1:0] ibuf_q, ibuf_d;
    logic            ibuf_vld_q, ibuf_vld_d;

    // Derived signals
    logic [XLEN-1:0] next_pc;
    logic            excp_adel;

    // Stall bits beyond IF/ID hold belong to later stages.
    logic            unused_stall;

    assign br_e         = bus.br_bus[32];
    assign br_addr      = bus.br_bus[31:0];
    assign pc_stop      = bus.stall[0];
    assign ifid_stop    = bus.stall[1];
    assign unused_stall = ^bus.stall[5:2];

    // Next fetch address: live branch beats a buffered redirect beats sequential.
    always_comb begin
        next_pc = pc_q + XLEN'(PC_STEP);
        if (br_e) begin
            next_pc = br_addr;
        end else if (redir_pend_q) begin
            next_pc = redir_addr_q;
        end
    end

    // PC advance and redirect buffering under PC hold.
    always_comb begin
        pc_d         = pc_q;
        ce_d         = ce_q;
        redir_pend_d = redir_pend_q;
        redir_addr_d = redir_addr_q;
        if (!pc_stop) begin
            pc_d         = next_pc;
            ce_d         = 1'b1;
            redir_pend_d = 1'b0;
        end else if (br_e) begin
            redir_pend_d = 1'b1;
            redir_addr_d = br_addr;
        end
    end

    // Skid buffer: capture the SRAM word on the first IF/ID-held cycle only.
    always_comb begin
        ibuf_d     = ibuf_q;
        ibuf_vld_d = ibuf_vld_q;
        if (ifid_stop) begin
            if (!ibuf_vld_q) begin
                ibuf_d     = bus.inst_sram_rdata;
                ibuf_vld_d = 1'b1;
            end
        end else begin
            ibuf_vld_d = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ce_q         <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_addr_q <= '0;
            ibuf_q       <= '0;
            ibuf_vld_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
            ibuf_q       <= ibuf_d;
            ibuf_vld_q   <= ibuf_vld_d;
        end
    end

    // Misaligned fetch raises AdEL and suppresses the SRAM access.
    assign excp_adel = ce_q & (pc_q[1:0] != 2'b00);

    // SRAM read port and ID-facing outputs.
    assign bus.inst_sram_en    = ce_q & ~excp_adel;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_q;
    assign bus.inst_sram_wdata = '0;
    assign bus.if_to_id_bus    = {excp_adel, ce_q, pc_q};
    assign bus.inst_to_id      = ibuf_vld_q ? ibuf_q : bus.inst_sram_rdata;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch with directed test-plan scenarios.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'hBFBF_FFFC;

    typedef struct {
        logic [31:0] addr;
        logic        en;
        logic [33:0] ifid;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    inst_fetch_if bus_if ();

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural PC, fetch-enabled flag, the redirect
    // waiting behind a PC hold, and the word held for a stalled ID.
    logic [31:0] m_pc;
    logic        m_fetching;
    logic [31:0] m_waiting[$];
    logic [31:0] m_held[$];

    // Inputs applied for the current cycle (the model consumes them at the edge).
    logic        a_rst;
    logic [5:0]  a_stall;
    logic        a_bre;
    logic [31:0] a_braddr;
    logic [31:0] a_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic adel;
        adel   = m_fetching && (m_pc % 4 != 0);
        e.addr = m_pc;
        e.en   = m_fetching && !adel;
        e.ifid = {adel, m_fetching, m_pc};
        e.inst = (m_held.size() != 0) ? m_held[0] : a_rdata;
        return e;
    endfunction

    task automatic model_edge();
        if (a_rst) begin
            m_pc = RST_PC;
            m_fetching = 1'b0;
            m_waiting.delete();
            m_held.delete();
        end else begin
            if (!a_stall[0]) begin
                if (a_bre)                      m_pc = a_braddr;
                else if (m_waiting.size() != 0) m_pc = m_waiting[0];
                else                            m_pc = m_pc + 32'd4;
                m_fetching = 1'b1;
                m_waiting.delete();
            end else if (a_bre) begin
                m_waiting.delete();
                m_waiting.push_back(a_braddr);
            end
            if (a_stall[1]) begin
                if (m_held.size() == 0) m_held.push_back(a_rdata);
            end else begin
                m_held.delete();
            end
        end
    endtask

    // Apply inputs for this cycle and queue the response the model predicts.
    task automatic drive(input logic r, input logic [5:0] st, input logic be,
                         input logic [31:0] ba, input logic [31:0] rd);
        a_rst = r; a_stall = st; a_bre = be; a_braddr = ba; a_rdata = rd;
        rst = r;
        bus_if.stall = st;
        bus_if.br_bus = {be, ba};
        bus_if.inst_sram_rdata = rd;
        sb.push_back(model_out());
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input logic r, input logic [5:0] st, input logic be,
                        input logic [31:0] ba, input logic [31:0] rd);
        drive(r, st, be, ba, rd);
        tick();
    endtask

    // Monitor: compare every presented cycle against the oldest prediction.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_addr",  64'(bus_if.inst_sram_addr), 64'(e.addr));
            chk("sb_en",    64'(bus_if.inst_sram_en),   64'(e.en));
            chk("sb_ifid",  64'(bus_if.if_to_id_bus),   64'(e.ifid));
            chk("sb_inst",  64'(bus_if.inst_to_id),     64'(e.inst));
            chk("sb_wen",   64'(bus_if.inst_sram_wen),  64'(4'b0000));
            chk("sb_wdata", 64'(bus_if.inst_sram_wdata), 64'(32'h0));
        end
    end

    initial begin
        logic [31:0] ba;
        logic [31:0] tmp;
        logic [5:0]  st;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus_if.stall = '0;
        bus_if.br_bus = '0;
        bus_if.inst_sram_rdata = 32'h0;
        a_rst = 1'b1; a_stall = '0; a_bre = 1'b0; a_braddr = '0; a_rdata = '0;
        @(posedge clk);
        model_edge();
        #1;

        // Reset and run
        step(1'b1, 6'd0, 1'b0, 32'h0, 32'hA5A5_0001);
        step(1'b1, 6'd0, 1'b0, 32'h0, 32'hA5A5_0002);
        chk("rst_addr", 64'(bus_if.inst_sram_addr), 64'(32'hBFBF_FFFC));
        chk("rst_en",   64'(bus_if.inst_sram_en), 64'(1'b0));
        chk("rst_ifid", 64'(bus_if.if_to_id_bus), 64'({2'b00, 32'hBFBF_FFFC}));
        drive(1'b0, 6'd0, 1'b0, 32'h0, 32'h1234_5678);
        chk("rst_inst_pass", 64'(bus_if.inst_to_id), 64'(32'h1234_5678));
        tick();
        chk("run_addr0", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0000));
        chk("run_en0",   64'(bus_if.inst_sram_en), 64'(1'b1));
        step(1'b0, 6'd0, 1'b0, 32'h0, 32'h0000_0001);
        chk("run_addr1", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0004));
        step(1'b0, 6'd0, 1'b0, 32'h0, 32'h0000_0002);
        chk("run_addr2", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0008));

        // Taken branch
        step(1'b0, 6'd0, 1'b1, 32'hBFC0_0100, 32'h0000_0003);
        chk("br_addr0", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0100));
        step(1'b0, 6'd0, 1'b0, 32'h0, 32'h0000_0004);
        chk("br_addr1", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0104));

        // Redirect under stall
        step(1'b0, 6'b000011, 1'b1, 32'hBFC0_0200, 32'h0000_0005);
        chk("rs_hold0", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0104));
        step(1'b0, 6'b000011, 1'b0, 32'h0, 32'h0000_0006);
        chk("rs_hold1", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0104));
        step(1'b0, 6'b000011, 1'b0, 32'h0, 32'h0000_0007);
        chk("rs_hold2", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0104));
        step(1'b0, 6'd0, 1'b0, 32'h0, 32'h0000_0008);
        chk("rs_target", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0200));

        // Skid buffer
        drive(1'b0, 6'b000010, 1'b0, 32'h0, 32'h3C08_0001);
        chk("skid_c0", 64'(bus_if.inst_to_id), 64'(32'h3C08_0001));
        tick();
        drive(1'b0, 6'b000010, 1'b0, 32'h0, 32'h3508_0002);
        chk("skid_c1", 64'(bus_if.inst_to_id), 64'(32'h3C08_0001));
        tick();
        drive(1'b0, 6'd0, 1'b0, 32'h0, 32'h1111_1111);
        chk("skid_release_cycle", 64'(bus_if.inst_to_id), 64'(32'h3C08_0001));
        tick();
        drive(1'b0, 6'd0, 1'b0, 32'h0, 32'h2222_2222);
        chk("skid_live", 64'(bus_if.inst_to_id), 64'(32'h2222_2222));
        tick();

        // Misaligned target
        step(1'b0, 6'd0, 1'b1, 32'hBFC0_0102, 32'h0);
        chk("adel_flag", 64'(bus_if.if_to_id_bus[33]), 64'(1'b1));
        chk("adel_en",   64'(bus_if.inst_sram_en), 64'(1'b0));
        chk("adel_pc",   64'(bus_if.if_to_id_bus[31:0]), 64'(32'hBFC0_0102));

        // Wrap
        step(1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        chk("wrap_pre", 64'(bus_if.inst_sram_addr), 64'(32'hFFFF_FFFC));
        step(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("wrap_zero", 64'(bus_if.inst_sram_addr), 64'(32'h0000_0000));

        // Reset overrides a pending redirect
        step(1'b0, 6'b000011, 1'b1, 32'hBFC0_0300, 32'h0);
        step(1'b1, 6'b000011, 1'b0, 32'h0, 32'h0);
        chk("rov_rst", 64'(bus_if.inst_sram_addr), 64'(32'hBFBF_FFFC));
        step(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("rov_first", 64'(bus_if.inst_sram_addr), 64'(32'hBFC0_0000));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            st = 6'($urandom());
            st[0] = ($urandom_range(0, 3) == 0);
            st[1] = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0: ba = 32'hFFFF_FFFC;
                1: begin
                    tmp = $urandom();
                    tmp[1:0] = 2'($urandom_range(1, 3));
                    ba = tmp;
                end
                default: ba = 32'hBFC0_0000 + 32'($urandom_range(0, 1023)) * 32'd4;
            endcase
            step(($urandom_range(0, 63) == 0), st, ($urandom_range(0, 5) == 0), ba, $urandom());
        end

        // Let the monitor consume the last prediction
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
